// File: rtl/tetris_pkg.sv
// Shared board geometry, cell-update record and writer state encoding
// for the Tetris board VRAM writer.
package tetris_pkg;

  localparam int ROWS          = 20;
  localparam int COLS          = 10;
  localparam int WORDS_PER_ROW = 3;

  typedef struct packed {
    logic [4:0] row;
    logic [3:0] col;
    logic [7:0] color;
  } cell_req_t;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    CLR,
    GAP
  } wr_state_t;

endpackage

// File: rtl/cell_fifo.sv
// Small synchronous FIFO holding pending cell updates; read data is the
// current head entry so the writer can pop and use it in the same cycle.
module cell_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset: only entries covered by count_reg are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/tetris_board_avl_writer.sv
// Turns queued per-cell board updates into single-byte Avalon-MM writes
// into board VRAM, and runs a full-board clear sweep on request.
module tetris_board_avl_writer #(
  parameter logic [11:0] BOARD_BASE    = 12'h000,
  parameter int          ROWS          = 20,
  parameter int          COLS          = 10,
  parameter int          WORDS_PER_ROW = 3,
  parameter int          DEPTH         = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [4:0]  IN_ROW,
  input  logic [3:0]  IN_COL,
  input  logic [7:0]  IN_COLOR,
  input  logic        CLR_REQ,
  output logic        BUSY,
  output logic        ERR_RANGE,
  output logic        AVL_CS,
  output logic        AVL_WRITE,
  output logic        AVL_READ,
  output logic [3:0]  AVL_BYTE_EN,
  output logic [11:0] AVL_ADDR,
  output logic [31:0] AVL_WRITEDATA,
  input  logic        AVL_WAITREQUEST
);
  import tetris_pkg::*;

  localparam int              SWEEP_WORDS = ROWS * WORDS_PER_ROW;
  localparam int              IW          = $clog2(SWEEP_WORDS);
  localparam logic [IW-1:0]   LAST_IDX    = IW'(SWEEP_WORDS - 1);

  wr_state_t     state_reg;
  logic          clr_pend_reg;
  logic          sweeping_reg;
  logic [IW-1:0] idx_reg;
  logic          err_reg;
  logic          cs_reg;
  logic          write_reg;
  logic [3:0]    be_reg;
  logic [11:0]   addr_reg;
  logic [31:0]   data_reg;

  cell_req_t     in_req;
  cell_req_t     head;
  logic          in_range;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          dispatch;
  logic [IW-1:0] idx_next;
  logic [11:0]   cell_addr;
  logic [3:0]    cell_be;

  assign in_req    = {IN_ROW, IN_COL, IN_COLOR};
  assign in_range  = (int'(IN_ROW) < ROWS) && (int'(IN_COL) < COLS);
  assign IN_READY  = RESET && !fifo_full;
  assign fifo_push = IN_VALID && IN_READY && in_range;

  // GAP also takes the next dispatch decision once a sweep is not in
  // progress, so back-to-back writes are separated by a single idle cycle.
  assign dispatch = (state_reg == IDLE) || (state_reg == GAP && !sweeping_reg);
  assign fifo_pop = dispatch && !clr_pend_reg && !fifo_empty;

  assign cell_addr = BOARD_BASE + 12'(head.row * WORDS_PER_ROW) + 12'(head.col[3:2]);
  assign cell_be   = 4'b0001 << head.col[1:0];
  assign idx_next  = idx_reg + IW'(1);

  cell_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(cell_req_t))
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET),
    .push  (fifo_push),
    .din   (in_req),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (head)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_reg    <= IDLE;
      clr_pend_reg <= 1'b0;
      sweeping_reg <= 1'b0;
      idx_reg      <= '0;
      err_reg      <= 1'b0;
      cs_reg       <= 1'b0;
      write_reg    <= 1'b0;
      be_reg       <= '0;
      addr_reg     <= '0;
      data_reg     <= '0;
    end else begin
      if (IN_VALID && IN_READY && !in_range) err_reg <= 1'b1;
      if (dispatch && clr_pend_reg) clr_pend_reg <= 1'b0;
      // A request in the same cycle the pending one is taken re-arms it.
      if (CLR_REQ) clr_pend_reg <= 1'b1;

      case (state_reg)
        WR: begin
          if (!AVL_WAITREQUEST) begin
            state_reg <= GAP;
            cs_reg    <= 1'b0;
            write_reg <= 1'b0;
          end
        end
        CLR: begin
          if (!AVL_WAITREQUEST) begin
            state_reg <= GAP;
            cs_reg    <= 1'b0;
            write_reg <= 1'b0;
            if (idx_reg == LAST_IDX) sweeping_reg <= 1'b0;
          end
        end
        default: begin
          if (state_reg == GAP && sweeping_reg) begin
            state_reg <= CLR;
            idx_reg   <= idx_next;
            addr_reg  <= BOARD_BASE + 12'(idx_next);
            cs_reg    <= 1'b1;
            write_reg <= 1'b1;
          end else if (clr_pend_reg) begin
            state_reg    <= CLR;
            sweeping_reg <= 1'b1;
            idx_reg      <= '0;
            addr_reg     <= BOARD_BASE;
            be_reg       <= 4'b1111;
            data_reg     <= '0;
            cs_reg       <= 1'b1;
            write_reg    <= 1'b1;
          end else if (!fifo_empty) begin
            state_reg <= WR;
            addr_reg  <= cell_addr;
            be_reg    <= cell_be;
            data_reg  <= {4{head.color}};
            cs_reg    <= 1'b1;
            write_reg <= 1'b1;
          end else begin
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

  assign BUSY          = !fifo_empty || clr_pend_reg || (state_reg != IDLE);
  assign ERR_RANGE     = err_reg;
  assign AVL_CS        = cs_reg;
  assign AVL_WRITE     = write_reg;
  assign AVL_READ      = 1'b0;
  assign AVL_BYTE_EN   = be_reg;
  assign AVL_ADDR      = addr_reg;
  assign AVL_WRITEDATA = data_reg;

endmodule

// File: tb/tb_tetris_board_avl_writer.sv
// Self-checking bench for tetris_board_avl_writer: directed timing sequences,
// a vector table, and a randomized run against a queue-based write model.
module tb_tetris_board_avl_writer;

  localparam int BASE = 0;
  localparam int WPR  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_row = '0;
  logic [3:0]  in_col = '0;
  logic [7:0]  in_color = '0;
  logic        clr_req = 1'b0;
  logic        avl_wait = 1'b0;
  logic        in_ready, busy, err_range;
  logic        avl_cs, avl_write, avl_read;
  logic [3:0]  avl_be;
  logic [11:0] avl_addr;
  logic [31:0] avl_data;

  typedef struct packed {
    logic [11:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    int          row;
    int          col;
    int          color;
    logic [11:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    bit          wr;
    bit          err;
  } vec_t;

  beat_t got_q[$];
  beat_t exp_q[$];
  vec_t  vecs[7];
  int    checks = 0;
  int    errors = 0;
  bit    read_seen = 1'b0;

  tetris_board_avl_writer dut (
    .CLK             (clk),
    .RESET           (rst_n),
    .IN_VALID        (in_valid),
    .IN_READY        (in_ready),
    .IN_ROW          (in_row),
    .IN_COL          (in_col),
    .IN_COLOR        (in_color),
    .CLR_REQ         (clr_req),
    .BUSY            (busy),
    .ERR_RANGE       (err_range),
    .AVL_CS          (avl_cs),
    .AVL_WRITE       (avl_write),
    .AVL_READ        (avl_read),
    .AVL_BYTE_EN     (avl_be),
    .AVL_ADDR        (avl_addr),
    .AVL_WRITEDATA   (avl_data),
    .AVL_WAITREQUEST (avl_wait)
  );

  always #5 clk = ~clk;

  // Beats are recorded mid-cycle; a beat with waitrequest low is accepted at the next edge.
  always @(negedge clk) begin
    if (avl_read) read_seen = 1'b1;
    if (rst_n && avl_cs && avl_write && !avl_wait)
      got_q.push_back({avl_addr, avl_be, avl_data});
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t model(input int row, input int col, input int color);
    beat_t b;
    b.addr = 12'((BASE + row * WPR + col / 4) % 4096);
    b.be   = 4'(1 << (col % 4));
    b.data = 32'(color % 256) * 32'h01010101;
    return b;
  endfunction

  task automatic set_cell(input int row, input int col, input int color);
    in_row   = 5'(row);
    in_col   = 4'(col);
    in_color = 8'(color);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      step();
      n++;
    end
    chk("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic wait_beats(input int n, input int limit);
    int k = 0;
    while (got_q.size() < n && k < limit) begin
      step();
      k++;
    end
    chk("beat_timeout", 64'(got_q.size() >= n), 64'(1));
  endtask

  task automatic compare_queues(input string name);
    chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk({name, "_beat"}, 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    int    accepted;
    int    stable_bad;
    bit    busy_drop;
    bit    exp_err;
    int    k;
    int    r, c, v;
    beat_t first;

    vecs[0] = '{5,  4,  'hA5, 12'h010, 4'b0001, 32'hA5A5A5A5, 1'b1, 1'b0};
    vecs[1] = '{10, 3,  'h7E, 12'h01E, 4'b1000, 32'h7E7E7E7E, 1'b1, 1'b0};
    vecs[2] = '{7,  6,  'hFF, 12'h016, 4'b0100, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[3] = '{19, 8,  'h3C, 12'h03B, 4'b0001, 32'h3C3C3C3C, 1'b1, 1'b0};
    vecs[4] = '{0,  10, 'h05, 12'h000, 4'b0000, 32'h00000000, 1'b0, 1'b1};
    vecs[5] = '{20, 0,  'h05, 12'h000, 4'b0000, 32'h00000000, 1'b0, 1'b1};
    vecs[6] = '{1,  1,  'h11, 12'h003, 4'b0010, 32'h11111111, 1'b1, 1'b1};

    // Reset state
    repeat (3) step();
    @(negedge clk);
    chk("rst_avl", 64'({avl_cs, avl_write, avl_read, avl_be, avl_addr}), 64'(0));
    chk("rst_data", 64'(avl_data), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err_range), 64'(0));
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    step();

    // Single write latency: valid in cycle c0, CS high after edge c0+2 for one cycle
    set_cell(0, 0, 'h06);
    in_valid = 1'b1;
    @(negedge clk);
    chk("lat_in_ready", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cs_early", 64'(avl_cs), 64'(0));
    step();
    @(negedge clk);
    chk("lat_cs_wr", 64'({avl_cs, avl_write}), 64'(2'b11));
    chk("lat_beat", 64'({avl_addr, avl_be, avl_data}), 64'({12'h000, 4'b0001, 32'h06060606}));
    step();
    @(negedge clk);
    chk("lat_cs_one_cycle", 64'(avl_cs), 64'(0));
    step();
    $display("txn single write (0,0,06) done");

    // Back-to-back pushes: writes separated by exactly one idle cycle
    wait_idle(20);
    set_cell(2, 7, 'h03);
    in_valid = 1'b1;
    step();
    set_cell(19, 9, 'h01);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_first", 64'({avl_cs, avl_addr, avl_be, avl_data}), 64'({1'b1, 12'h007, 4'b1000, 32'h03030303}));
    step();
    @(negedge clk);
    chk("b2b_gap", 64'(avl_cs), 64'(0));
    step();
    @(negedge clk);
    chk("b2b_second", 64'({avl_cs, avl_addr, avl_be, avl_data}), 64'({1'b1, 12'h03B, 4'b0010, 32'h01010101}));
    step();
    @(negedge clk);
    chk("b2b_end", 64'(avl_cs), 64'(0));
    step();
    $display("txn back-to-back writes done");

    // Vector table
    for (int i = 0; i < 7; i++) begin
      wait_idle(20);
      got_q.delete();
      set_cell(vecs[i].row, vecs[i].col, vecs[i].color);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (6) step();
      if (vecs[i].wr) begin
        chk($sformatf("tbl%0d_count", i), 64'(got_q.size()), 64'(1));
        if (got_q.size() >= 1)
          chk($sformatf("tbl%0d_beat", i), 64'(got_q[0]), 64'({vecs[i].addr, vecs[i].be, vecs[i].data}));
      end else begin
        chk($sformatf("tbl%0d_nowrite", i), 64'(got_q.size()), 64'(0));
      end
      chk($sformatf("tbl%0d_err", i), 64'(err_range), 64'(vecs[i].err));
      $display("txn vec %0d row %0d col %0d colour %0h writes %0d", i, vecs[i].row, vecs[i].col, vecs[i].color, got_q.size());
    end

    // Clear sweep with a cell pushed mid-sweep
    wait_idle(20);
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 60; i++) exp_q.push_back({12'(BASE + i), 4'b1111, 32'h0});
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (10) step();
    chk("clr_busy", 64'(busy), 64'(1));
    set_cell(4, 5, 'h42);
    in_valid = 1'b1;
    @(negedge clk);
    chk("clr_push_ready", 64'(in_ready), 64'(1));
    exp_q.push_back(model(4, 5, 'h42));
    step();
    in_valid = 1'b0;
    busy_drop = 1'b0;
    k = 0;
    while (got_q.size() < 61 && k < 400) begin
      if (got_q.size() < 60 && !busy) busy_drop = 1'b1;
      step();
      k++;
    end
    chk("clr_busy_held", 64'(busy_drop), 64'(0));
    compare_queues("clr");
    $display("txn clear sweep beats %0d", got_q.size());

    // Stalled write while the FIFO fills
    wait_idle(20);
    got_q.delete();
    exp_q.delete();
    avl_wait = 1'b1;
    accepted = 0;
    stable_bad = 0;
    first = model(0, 0, 'h80);
    for (int i = 0; i < 20; i++) begin
      r = i % 20;
      c = (i * 3) % 10;
      v = 'h80 + i;
      set_cell(r, c, v);
      in_valid = 1'b1;
      @(negedge clk);
      if (i >= 2 && !(avl_cs && avl_write && {avl_addr, avl_be, avl_data} == first)) stable_bad++;
      if (!in_ready) break;
      accepted++;
      exp_q.push_back(model(r, c, v));
      step();
    end
    in_valid = 1'b0;
    step();
    chk("stall_accepted", 64'(accepted), 64'(9));
    chk("stall_stable", 64'(stable_bad), 64'(0));
    chk("stall_full", 64'(in_ready), 64'(0));
    avl_wait = 1'b0;
    wait_beats(9, 60);
    compare_queues("stall");
    $display("txn stall fill accepted %0d written %0d", accepted, got_q.size());

    // Reset mid-transaction with queued entries
    wait_idle(20);
    got_q.delete();
    avl_wait = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_cell(i, i, 'h20 + i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("mrst_pre_wr", 64'(avl_cs), 64'(1));
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_in_ready", 64'(in_ready), 64'(0));
    step();
    @(negedge clk);
    chk("mrst_avl", 64'({avl_cs, avl_write, avl_read, avl_be, avl_addr}), 64'(0));
    chk("mrst_data", 64'(avl_data), 64'(0));
    chk("mrst_busy", 64'(busy), 64'(0));
    chk("mrst_err", 64'(err_range), 64'(0));
    step();
    rst_n = 1'b1;
    avl_wait = 1'b0;
    repeat (20) step();
    chk("mrst_no_write", 64'(got_q.size()), 64'(0));
    chk("mrst_idle", 64'(busy), 64'(0));
    $display("txn reset mid-write done");

    // Randomized traffic against the queue model
    got_q.delete();
    exp_q.delete();
    exp_err = 1'b0;
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 21));
      c = int'($urandom_range(0, 11));
      v = int'($urandom_range(0, 255));
      set_cell(r, c, v);
      in_valid = ($urandom_range(0, 3) != 0);
      avl_wait = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (r < 20 && c < 10) exp_q.push_back(model(r, c, v));
        else exp_err = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    avl_wait = 1'b0;
    wait_idle(200);
    compare_queues("rand");
    chk("rand_err", 64'(err_range), 64'(exp_err));
    chk("no_avl_read", 64'(read_seen), 64'(0));
    $display("txn random run writes %0d", got_q.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
